// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: 8-bit ALU, EX/MEM register, optional shift-add MUL (macro EX_MUL_EN)
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwrite_idex_input,
  input  logic        mem_read_idex_input,
  input  logic        mem_write_idex_input,
  input  logic        mem_to_reg_idex_input,
  input  logic        alu_src_idex_input,
  input  logic [7:0]  read_data_1_idex_input,
  input  logic [7:0]  read_data_2_idex_input,
  input  logic [15:0] instruction_idex_input,
  output logic        regwrite_exmem_output,
  output logic        mem_read_exmem_output,
  output logic        mem_write_exmem_output,
  output logic        mem_to_reg_exmem_output,
  output logic [7:0]  alu_result_exmem_output,
  output logic [7:0]  write_data_exmem_output,
  output logic [2:0]  rd_exmem_output,
  output logic        stall_ex_output
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_LW  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;

  logic [3:0] w_opcode;
  logic [2:0] w_rd;
  logic [7:0] w_imm_sext;
  logic [7:0] w_operand_a;
  logic [7:0] w_operand_b;
  logic [7:0] w_alu_result;
  logic       w_is_nop;
  logic [3:0] w_ctrl_in;
  logic       w_unused_rs_fields;

  // Values the MUL path hands to the EX/MEM register in its DONE cycle.
  logic       w_stall;
  logic       w_mul_done;
  logic [7:0] w_mul_result;
  logic [7:0] w_mul_wdata;
  logic [2:0] w_mul_rd;
  logic [3:0] w_mul_ctrl;

  assign w_opcode    = instruction_idex_input[15:12];
  assign w_rd        = instruction_idex_input[11:9];
  assign w_imm_sext  = {{2{instruction_idex_input[5]}}, instruction_idex_input[5:0]};
  assign w_operand_a = read_data_1_idex_input;
  assign w_operand_b = alu_src_idex_input ? w_imm_sext : read_data_2_idex_input;
  assign w_ctrl_in   = {regwrite_idex_input, mem_read_idex_input,
                        mem_write_idex_input, mem_to_reg_idex_input};
  // Operands arrive already read, so the rs1 field is not needed here.
  assign w_unused_rs_fields = ^instruction_idex_input[8:6];

  // Opcode 8 never reaches the single-cycle path as a real op: with the
  // multiplier it is intercepted by the stall, without it it is a NOP.
  assign w_is_nop = (w_opcode >= 4'hB) || (w_opcode == OP_MUL);

  // Single-cycle ALU; memory ops always address with rs1 + imm regardless of alu_src.
  always_comb begin
    w_alu_result = 8'h00;
    case (w_opcode)
      OP_ADD:  w_alu_result = w_operand_a + w_operand_b;
      OP_SUB:  w_alu_result = w_operand_a - w_operand_b;
      OP_AND:  w_alu_result = w_operand_a & w_operand_b;
      OP_OR:   w_alu_result = w_operand_a | w_operand_b;
      OP_XOR:  w_alu_result = w_operand_a ^ w_operand_b;
      OP_SLL:  w_alu_result = w_operand_a << w_operand_b[2:0];
      OP_SRL:  w_alu_result = w_operand_a >> w_operand_b[2:0];
      OP_SLT:  w_alu_result = ($signed(w_operand_a) < $signed(w_operand_b)) ? 8'd1 : 8'd0;
      OP_LW:   w_alu_result = w_operand_a + w_imm_sext;
      OP_SW:   w_alu_result = w_operand_a + w_imm_sext;
      default: w_alu_result = 8'h00;
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  mul_state_t r_state;
  mul_state_t w_state_next;
  logic       w_mul_start;
  logic [2:0] r_cnt;
  logic [7:0] r_acc;
  logic [7:0] r_mcand;
  logic [7:0] r_mplier;
  logic [7:0] r_wdata_hold;
  logic [2:0] r_rd_hold;
  logic [3:0] r_ctrl_hold;

  // MUL state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // MUL next state and stall; DONE always returns to IDLE so a held MUL cannot retrigger.
  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_mul_start  = 1'b0;
    w_mul_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_opcode == OP_MUL) begin
          w_stall      = 1'b1;
          w_mul_start  = 1'b1;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == 3'd7) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_mul_done   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Shift-add datapath: operands and MUL controls are captured once at start so
  // input activity during BUSY cannot disturb the product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= 3'd0;
      r_acc        <= 8'h00;
      r_mcand      <= 8'h00;
      r_mplier     <= 8'h00;
      r_wdata_hold <= 8'h00;
      r_rd_hold    <= 3'd0;
      r_ctrl_hold  <= 4'h0;
    end else if (w_mul_start) begin
      r_cnt        <= 3'd0;
      r_acc        <= 8'h00;
      r_mcand      <= w_operand_a;
      r_mplier     <= w_operand_b;
      r_wdata_hold <= read_data_2_idex_input;
      r_rd_hold    <= w_rd;
      r_ctrl_hold  <= w_ctrl_in;
    end else if (r_state == S_BUSY) begin
      r_acc    <= r_acc + (r_mplier[0] ? r_mcand : 8'h00);
      r_mcand  <= {r_mcand[6:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[7:1]};
      r_cnt    <= r_cnt + 3'd1;
    end
  end

  assign w_mul_result = r_acc;
  assign w_mul_wdata  = r_wdata_hold;
  assign w_mul_rd     = r_rd_hold;
  assign w_mul_ctrl   = r_ctrl_hold;
`else
  assign w_stall      = 1'b0;
  assign w_mul_done   = 1'b0;
  assign w_mul_result = 8'h00;
  assign w_mul_wdata  = 8'h00;
  assign w_mul_rd     = 3'd0;
  assign w_mul_ctrl   = 4'h0;
`endif

  assign stall_ex_output = w_stall;

  // EX/MEM register: bubble while stalled, MUL product in DONE, else the ALU result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_exmem_output   <= 1'b0;
      mem_read_exmem_output   <= 1'b0;
      mem_write_exmem_output  <= 1'b0;
      mem_to_reg_exmem_output <= 1'b0;
      alu_result_exmem_output <= 8'h00;
      write_data_exmem_output <= 8'h00;
      rd_exmem_output         <= 3'd0;
    end else if (w_stall) begin
      regwrite_exmem_output   <= 1'b0;
      mem_read_exmem_output   <= 1'b0;
      mem_write_exmem_output  <= 1'b0;
      mem_to_reg_exmem_output <= 1'b0;
      alu_result_exmem_output <= 8'h00;
      write_data_exmem_output <= 8'h00;
      rd_exmem_output         <= 3'd0;
    end else if (w_mul_done) begin
      {regwrite_exmem_output, mem_read_exmem_output,
       mem_write_exmem_output, mem_to_reg_exmem_output} <= w_mul_ctrl;
      alu_result_exmem_output <= w_mul_result;
      write_data_exmem_output <= w_mul_wdata;
      rd_exmem_output         <= w_mul_rd;
    end else begin
      {regwrite_exmem_output, mem_read_exmem_output,
       mem_write_exmem_output, mem_to_reg_exmem_output} <= w_is_nop ? 4'h0 : w_ctrl_in;
      alu_result_exmem_output <= w_alu_result;
      write_data_exmem_output <= read_data_2_idex_input;
      rd_exmem_output         <= w_rd;
    end
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  input  1  single pipeline clock; all state updates on posedge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately, independent of clk.
REQ-003 regwrite_idex_input, mem_read_idex_input, mem_write_idex_input, mem_to_reg_idex_input, alu_src_idex_input  input  1 each  control bits from the ID/EX register.
REQ-004 read_data_1_idex_input, read_data_2_idex_input  input  8 each  register operands rs1 and rs2 from ID/EX.
REQ-005 instruction_idex_input  input  16  instruction from ID/EX: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6.
REQ-006 regwrite_exmem_output, mem_read_exmem_output, mem_write_exmem_output, mem_to_reg_exmem_output  output  1 each  registered control to the MEM stage.
REQ-007 alu_result_exmem_output  output  8  registered ALU result or memory address.
REQ-008 write_data_exmem_output  output  8  registered store data, equal to rs2.
REQ-009 rd_exmem_output  output  3  registered destination register.
REQ-010 stall_ex_output  output  1  combinational; 1 = upstream SHALL hold PC, IF/ID and ID/EX unchanged.

Function
REQ-011 Operand B SHALL be sign-extended imm6 when alu_src=1, otherwise rs2; all arithmetic is 8-bit modulo 256 with no carry or overflow output.
REQ-012 Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SLL by B[2:0], 6 SRL (logical) by B[2:0], 7 SLT (signed, result 1 or 0), 8 MUL (low 8 bits of the unsigned product), 9 LW, A SW; LW and SW SHALL compute A + sign-extended imm6.
REQ-013 Opcodes B-F SHALL be NOPs: EX/MEM control bits forced to 0, while data fields still load their computed values.
REQ-014 For every opcode except MUL, the EX/MEM register SHALL load on the next posedge after the instruction is presented (1-cycle latency), with control bits copied from the inputs.
REQ-015 MUL SHALL be a shift-add FSM with states IDLE, BUSY and DONE and a 3-bit iteration counter.
REQ-016 In IDLE with opcode 8 presented: stall=1; at the posedge, latch both operands, clear the accumulator, set cnt=0 and move to BUSY.
REQ-017 In BUSY: stall=1; each posedge performs one iteration; when cnt=7 the state moves to DONE, so there are exactly 8 BUSY cycles.
REQ-018 In DONE: stall=0; at the posedge, EX/MEM loads the product low byte with the held MUL controls and the state returns to IDLE.
REQ-019 Whole MUL timing: stall is high for 9 consecutive cycles and the result appears in EX/MEM at the 10th posedge after first presentation.
REQ-020 The held MUL instruction SHALL NOT retrigger the FSM while in DONE.
REQ-021 On every posedge where stall=1, EX/MEM SHALL load a bubble: all control bits 0, and rd, alu_result and write_data all 0.
REQ-022 Back-to-back MULs: a second MUL presented in the cycle after DONE SHALL start a new 9-cycle stall; no cycle is lost and none is overlapped.
REQ-023 Operand values on the inputs during BUSY SHALL NOT affect the product, because the operands are latched.

Reset
REQ-024 While rst=0: all EX/MEM outputs are 0, the FSM is in IDLE, cnt=0, the accumulator and latched operands are 0, and stall_ex_output=0.
REQ-025 Reset asserted mid-MUL SHALL abort the operation; after release the FSM is in IDLE and re-evaluates the current input at the next posedge.

Configuration
REQ-026 Macro EX_MUL_EN: when defined, the MUL FSM and the stall logic are compiled in as specified above.
REQ-027 When EX_MUL_EN is undefined: opcode 8 is a NOP per REQ-013, stall_ex_output is tied to 0, and no FSM, counter or accumulator registers exist.

Verification
REQ-028 Stimulus: ADD, rs1=0x7F, rs2=0x01, alu_src=0, rd=3, regwrite=1. Required response one posedge later: alu_result=0x80, rd=3, regwrite=1.
REQ-029 Stimulus: LW, rs1=0x10, imm6=0x3E (-2), alu_src=1. Required response: alu_result=0x0E, mem_read=1, mem_to_reg=1. Stimulus: SW, rs2=0xA5. Required response: write_data=0xA5, mem_write=1.
REQ-030 Stimulus: MUL, rs1=0x0D, rs2=0x0B, held during stall (EX_MUL_EN defined). Required response: stall high for exactly 9 cycles, 9 bubbles loaded, then alu_result=0x8F at the 10th posedge.
REQ-031 Stimulus: MUL 0xFF*0xFF, with the inputs toggled randomly during BUSY. Required response: result 0x01, unaffected by the toggling.
REQ-032 Stimulus: rst driven low at BUSY cnt=4, then released, with a NOP presented. Required response: all outputs 0 immediately, stall=0, and the FSM in IDLE.
REQ-033 Stimulus: build without EX_MUL_EN and present MUL with regwrite=1. Required response: stall never asserts, and regwrite_exmem=0.
